// File: rtl/sum_splitter.sv
// Splits one total across NUM_OUTPUT lanes using a shared restoring divider.
// Define SUM_SPLITTER_REMAINDER_ROTATE_EN to rotate remainder units round-robin.
module sum_splitter #(
   parameter int NUM_OUTPUT = 4,
   parameter int WIDTH      = 16,
   parameter bit IS_SIGNED  = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data [NUM_OUTPUT]
);

   localparam int RW = $clog2(NUM_OUTPUT + 1) + 1;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [RW-1:0] DIV = RW'(NUM_OUTPUT);

   typedef enum logic [1:0] {IDLE, DIVIDE, LOAD, HOLD} state_e;

   state_e           state_q, state_d;
   logic             sign_q, sign_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [RW-1:0]    rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q [NUM_OUTPUT];
   logic [WIDTH-1:0] lane_d [NUM_OUTPUT];

   logic             accept, step_en, load_en, done_en;
   logic [WIDTH-1:0] mag;
   logic [RW-1:0]    trial;
   logic             take;

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (i_valid) state_d = DIVIDE;
         DIVIDE:  if (cnt_q == '0) state_d = LOAD;
         LOAD:    state_d = HOLD;
         HOLD:    if (i_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_ready = 1'b0;
      accept  = 1'b0;
      step_en = 1'b0;
      load_en = 1'b0;
      done_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            o_ready = i_rst_n;
            accept  = i_valid;
         end
         DIVIDE:  step_en = 1'b1;
         LOAD:    load_en = 1'b1;
         HOLD:    done_en = i_ready;
         default: ;
      endcase
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;

   // Two's-complement minimum negates to itself, which is the right magnitude
   assign mag   = (IS_SIGNED && i_data[WIDTH-1]) ? -i_data : i_data;
   assign trial = {rem_q[RW-2:0], quo_q[WIDTH-1]};
   assign take  = (trial >= DIV);

`ifdef SUM_SPLITTER_REMAINDER_ROTATE_EN
   logic [RW-1:0] rot_q, rot_d;
   logic [RW-1:0] rot_sum;

   assign rot_sum = rot_q + rem_q;
   assign rot_d   = (rot_sum >= DIV) ? rot_sum - DIV : rot_sum;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     rot_q <= '0;
      else if (load_en) rot_q <= rot_d;
   end
`endif

   for (genvar g = 0; g < NUM_OUTPUT; g++) begin : g_lane
      logic             bump;
      logic [WIDTH-1:0] part;
`ifdef SUM_SPLITTER_REMAINDER_ROTATE_EN
      logic [RW-1:0] rel;
      assign rel  = (RW'(g) >= rot_q) ? RW'(g) - rot_q
                                      : RW'(g) + DIV - rot_q;
      assign bump = (rel < rem_q);
`else
      assign bump = (RW'(g) < rem_q);
`endif
      assign part      = quo_q + WIDTH'(bump);
      assign lane_d[g] = sign_q ? -part : part;
   end

   always_comb begin
      sign_d  = sign_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      if (accept) begin
         sign_d = IS_SIGNED & i_data[WIDTH-1];
         quo_d  = mag;
         rem_d  = '0;
         cnt_d  = CW'(WIDTH - 1);
      end
      if (step_en) begin
         rem_d = take ? trial - DIV : trial;
         quo_d = WIDTH'({quo_q, take});
         cnt_d = cnt_q - 1'b1;
      end
      if (load_en) valid_d = 1'b1;
      if (done_en) valid_d = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sign_q  <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         sign_q  <= sign_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_OUTPUT; i++) data_q[i] <= '0;
      end else if (load_en) begin
         data_q <= lane_d;
      end
   end

endmodule

// File: tb/tb_sum_splitter.sv
// Directed bench for sum_splitter: four WIDTH=8 instances share one stream.
// A: N=3 unsigned, B: N=2 signed, C: N=3 signed, D: N=1 signed.
module tb_sum_splitter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       iv = 1'b0;
   logic       ir = 1'b1;
   logic [7:0] id = 8'd0;

   logic       rdy_a, rdy_b, rdy_c, rdy_d;
   logic       ov_a, ov_b, ov_c, ov_d;
   logic [7:0] od_a [3];
   logic [7:0] od_b [2];
   logic [7:0] od_c [3];
   logic [7:0] od_d [1];

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   sum_splitter #(.NUM_OUTPUT(3), .WIDTH(8), .IS_SIGNED(1'b0)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv), .o_ready(rdy_a),
      .i_data(id), .o_valid(ov_a), .i_ready(ir), .o_data(od_a));
   sum_splitter #(.NUM_OUTPUT(2), .WIDTH(8), .IS_SIGNED(1'b1)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv), .o_ready(rdy_b),
      .i_data(id), .o_valid(ov_b), .i_ready(ir), .o_data(od_b));
   sum_splitter #(.NUM_OUTPUT(3), .WIDTH(8), .IS_SIGNED(1'b1)) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv), .o_ready(rdy_c),
      .i_data(id), .o_valid(ov_c), .i_ready(ir), .o_data(od_c));
   sum_splitter #(.NUM_OUTPUT(1), .WIDTH(8), .IS_SIGNED(1'b1)) u_d (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv), .o_ready(rdy_d),
      .i_data(id), .o_valid(ov_d), .i_ready(ir), .o_data(od_d));

   typedef struct packed {
      logic [7:0] din;
      logic [7:0] a0, a1, a2;
      logic [7:0] b0, b1;
      logic [7:0] c0, c1, c2;
      logic [7:0] d;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_a(input string name, input int e0, input int e1,
                        input int e2);
      chk({name, "_a0"}, od_a[0], e0);
      chk({name, "_a1"}, od_a[1], e1);
      chk({name, "_a2"}, od_a[2], e2);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      iv = 1'b0;
      ir = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send(input logic [7:0] d);
      int n;
      n = 0;
      @(negedge clk);
      while (!rdy_a && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", rdy_a, 1);
      iv = 1'b1;
      id = d;
      @(posedge clk);
      #1 iv = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ov_a && n < 40);
      chk("valid_timeout", ov_a, 1);
   endtask

   task automatic check_vec(input int k, input vec_t v);
      string s;
      s = $sformatf("v%0d", k);
      chk({s, "_a0"}, od_a[0], v.a0);
      chk({s, "_a1"}, od_a[1], v.a1);
      chk({s, "_a2"}, od_a[2], v.a2);
      chk({s, "_b0"}, od_b[0], v.b0);
      chk({s, "_b1"}, od_b[1], v.b1);
      chk({s, "_c0"}, od_c[0], v.c0);
      chk({s, "_c1"}, od_c[1], v.c1);
      chk({s, "_c2"}, od_c[2], v.c2);
      chk({s, "_d"},  od_d[0], v.d);
      chk({s, "_vld_bcd"}, {29'd0, ov_b, ov_c, ov_d}, 7);
      chk({s, "_sum_a"}, int'(od_a[0]) + int'(od_a[1]) + int'(od_a[2]),
          int'(v.din));
      chk({s, "_sum_b"}, int'($signed(od_b[0])) + int'($signed(od_b[1])),
          int'($signed(v.din)));
      chk({s, "_sum_c"}, int'($signed(od_c[0])) + int'($signed(od_c[1]))
          + int'($signed(od_c[2])), int'($signed(v.din)));
      chk({s, "_sum_d"}, int'($signed(od_d[0])), int'($signed(v.din)));
   endtask

   initial begin
      int n;

      tbl[0] = '{8'h0A, 8'd4, 8'd3, 8'd3, 8'd5, 8'd5,
                 8'd4, 8'd3, 8'd3, 8'h0A};
      tbl[1] = '{8'hF9, 8'h53, 8'h53, 8'h53, 8'hFC, 8'hFD,
                 8'hFD, 8'hFE, 8'hFE, 8'hF9};
      tbl[2] = '{8'h80, 8'h2B, 8'h2B, 8'h2A, 8'hC0, 8'hC0,
                 8'hD5, 8'hD5, 8'hD6, 8'h80};
      tbl[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[4] = '{8'h02, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1,
                 8'd1, 8'd1, 8'd0, 8'h02};
      tbl[5] = '{8'hFE, 8'h55, 8'h55, 8'h54, 8'hFF, 8'hFF,
                 8'hFF, 8'hFF, 8'h00, 8'hFE};
      tbl[6] = '{8'hFF, 8'h55, 8'h55, 8'h55, 8'hFF, 8'h00,
                 8'hFF, 8'h00, 8'h00, 8'hFF};
      tbl[7] = '{8'h7F, 8'h2B, 8'h2A, 8'h2A, 8'h40, 8'h3F,
                 8'h2B, 8'h2A, 8'h2A, 8'h7F};

      // Reset state
      #12;
      chk("rst_valid", ov_a, 0);
      chk("rst_ready", rdy_a, 0);
      chk("rst_lane0", od_a[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("idle_ready", rdy_a, 1);

      // Remainder placement over three identical totals
      for (int k = 0; k < 3; k++) begin
         send(8'd10);
         wait_valid(n);
`ifdef SUM_SPLITTER_REMAINDER_ROTATE_EN
         chk_a($sformatf("rot%0d", k), (k == 0) ? 4 : 3,
               (k == 1) ? 4 : 3, (k == 2) ? 4 : 3);
`else
         chk_a($sformatf("rot%0d", k), 4, 3, 3);
`endif
      end
      send(8'd10);
      wait_valid(n);
      chk_a("rot_wrap", 4, 3, 3);

      // Table vectors with latency and drop checks
      for (int k = 0; k < 8; k++) begin
`ifdef SUM_SPLITTER_REMAINDER_ROTATE_EN
         do_reset();
`endif
         send(tbl[k].din);
         wait_valid(n);
         chk($sformatf("v%0d_latency", k), n, 9);
         check_vec(k, tbl[k]);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_drop", k), ov_a, 0);
      end

      // Backpressure and busy input
      do_reset();
      ir = 1'b0;
      send(8'd10);
      @(negedge clk);
      chk("busy_ready", rdy_a, 0);
      iv = 1'b1;
      id = 8'd5;
      @(posedge clk);
      #1 iv = 1'b0;
      wait_valid(n);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_valid", k), ov_a, 1);
         chk_a($sformatf("bp%0d", k), 4, 3, 3);
      end
      @(negedge clk);
      ir = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_drop", ov_a, 0);
      chk_a("bp_keep", 4, 3, 3);
      send(8'd5);
      wait_valid(n);
`ifdef SUM_SPLITTER_REMAINDER_ROTATE_EN
      chk_a("bp_next", 1, 2, 2);
`else
      chk_a("bp_next", 2, 2, 1);
`endif

      // Reset during the third divide cycle
      send(8'd10);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_valid", ov_a, 0);
      chk("mid_ready", rdy_a, 0);
      chk_a("mid_clr", 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_ready_rel", rdy_a, 1);
      @(posedge clk);
      #1;
      chk("mid_no_valid", ov_a, 0);
      send(8'd6);
      wait_valid(n);
      chk("mid_latency", n, 9);
      chk_a("mid_next", 2, 2, 2);
      chk("mid_next_c0", od_c[0], 2);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
